simmem_idlist_buffer: RTL and testbench

Per-ID ordered message buffer for the simulated memory controller. It holds up to `TotalCapacity` messages in one shared flop-based store, threaded into one linked list per AXI ID. It releases the head of any list whose ID is release-enabled. It generalises the first-generation linked-list bank with:
- simultaneous push and pop in one cycle;
- exact per-ID occupancy tracking and a full flag;
- selectable fixed-priority or round-robin release arbitration.

---
 rtl/simmem_idlist_buffer_pkg.sv | 19 +
 rtl/simmem_idlist_buffer_if.sv | 27 ++
 rtl/simmem_id_arbiter.sv | 40 ++++
 rtl/simmem_idlist_buffer.sv | 143 ++++++++++++++
 tb/tb_simmem_idlist_buffer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/simmem_idlist_buffer_pkg.sv
// Shared types and width helpers for the simulated memory controller buffers.
package simmem_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_ROUND_ROBIN
    } arb_mode_e;

    // Slot index width for a store of the given capacity (capacity >= 2).
    function automatic int unsigned addr_width(input int unsigned capacity);
        return $clog2(capacity);
    endfunction

    // Counter width able to hold 0..capacity inclusive.
    function automatic int unsigned len_width(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/simmem_idlist_buffer_if.sv
// Input/output handshake bundle of the per-ID list buffer.
interface simmem_idlist_buffer_if #(
    parameter int unsigned StructWidth = 64,
    parameter int unsigned IDWidth     = 4
);
    localparam int unsigned NumIds = 2 ** IDWidth;

    logic [NumIds-1:0]      release_en_i;
    logic [StructWidth-1:0] data_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [StructWidth-1:0] data_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [NumIds-1:0]      nonempty_o;
    logic                   full_o;

    modport master (
        output release_en_i, data_i, in_valid_i, out_ready_i,
        input  in_ready_o, data_o, out_valid_o, nonempty_o, full_o
    );

    modport slave (
        input  release_en_i, data_i, in_valid_i, out_ready_i,
        output in_ready_o, data_o, out_valid_o, nonempty_o, full_o
    );
endinterface

// File: rtl/simmem_id_arbiter.sv
// Picks one ID out of an eligibility vector, either lowest-first or
// round-robin starting at rr_i.
module simmem_id_arbiter
    import simmem_pkg::*;
#(
    parameter int unsigned IDWidth = 4,
    parameter arb_mode_e   ArbMode = ARB_ROUND_ROBIN,
    localparam int unsigned NumIds = 2 ** IDWidth
) (
    input  logic [NumIds-1:0]  eligible_i,
    input  logic [IDWidth-1:0] rr_i,
    output logic [NumIds-1:0]  grant_o,
    output logic [IDWidth-1:0] sel_o,
    output logic               any_o
);

    // Scan candidates in priority order; the first eligible one wins.
    always_comb begin
        logic [IDWidth-1:0] idx;
        sel_o   = '0;
        any_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (ArbMode == ARB_ROUND_ROBIN) begin
                idx = rr_i + IDWidth'(i);
            end else begin
                idx = IDWidth'(i);
            end
            if (!any_o && eligible_i[idx]) begin
                any_o = 1'b1;
                sel_o = idx;
            end
        end
        if (any_o) begin
            grant_o[sel_o] = 1'b1;
        end
    end

endmodule

// File: rtl/simmem_idlist_buffer.sv
// Shared-store message buffer holding one ordered linked list per AXI ID,
// releasing the head of any release-enabled list.
module simmem_idlist_buffer
    import simmem_pkg::*;
#(
    parameter int unsigned StructWidth   = 64,
    parameter int unsigned TotalCapacity = 16,
    parameter int unsigned IDWidth       = 4,
    parameter arb_mode_e   ArbMode       = ARB_ROUND_ROBIN
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    simmem_idlist_buffer_if.slave bus
);

    localparam int unsigned AddrW  = addr_width(TotalCapacity);
    localparam int unsigned LenW   = len_width(TotalCapacity);
    localparam int unsigned NumIds = 2 ** IDWidth;
    localparam int unsigned PayW   = StructWidth - IDWidth;

    logic [PayW-1:0]          payload_q [TotalCapacity];
    logic [AddrW-1:0]         next_q    [TotalCapacity];
    logic [TotalCapacity-1:0] free_q, free_d;
    logic [AddrW-1:0]         head_q [NumIds];
    logic [AddrW-1:0]         head_d [NumIds];
    logic [AddrW-1:0]         tail_q [NumIds];
    logic [AddrW-1:0]         tail_d [NumIds];
    logic [LenW-1:0]          len_q  [NumIds];
    logic [LenW-1:0]          len_d  [NumIds];
    logic [IDWidth-1:0]       rr_q, rr_d;

    logic [NumIds-1:0]  eligible;
    logic [NumIds-1:0]  grant;
    logic [IDWidth-1:0] sel;
    logic               any_elig;
    logic [AddrW-1:0]   free_idx;
    logic [IDWidth-1:0] in_id;
    logic               push, pop, link_we;

    assign in_id = bus.data_i[IDWidth-1:0];

    // Per-ID eligibility and occupancy flags.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NumIds; k++) begin
            eligible[k] = (len_q[k] != '0) && bus.release_en_i[k];
        end
    end

    simmem_id_arbiter #(
        .IDWidth (IDWidth),
        .ArbMode (ArbMode)
    ) u_arbiter (
        .eligible_i (eligible),
        .rr_i       (rr_q),
        .grant_o    (grant),
        .sel_o      (sel),
        .any_o      (any_elig)
    );

    // Lowest-index free slot; descending scan so the lowest hit is kept.
    always_comb begin
        free_idx = '0;
        for (int unsigned i = TotalCapacity; i > 0; i--) begin
            if (free_q[i-1]) begin
                free_idx = AddrW'(i - 1);
            end
        end
    end

    assign bus.full_o      = ~|free_q;
    assign bus.in_ready_o  = |free_q;
    assign bus.out_valid_o = any_elig;
    assign bus.data_o      = {payload_q[head_q[sel]], sel};
    always_comb begin
        for (int unsigned k = 0; k < NumIds; k++) begin
            bus.nonempty_o[k] = (len_q[k] != '0);
        end
    end

    assign push = bus.in_valid_i && |free_q;
    assign pop  = any_elig && bus.out_ready_i;

    // Next-state of list bookkeeping. The pop is applied before the push, so a
    // same-ID push that meets a draining single-entry list starts a new list.
    always_comb begin
        free_d  = free_q;
        head_d  = head_q;
        tail_d  = tail_q;
        len_d   = len_q;
        rr_d    = rr_q;
        link_we = 1'b0;
        for (int unsigned k = 0; k < NumIds; k++) begin
            if (pop && grant[k]) begin
                free_d[head_q[k]] = 1'b1;
                head_d[k]         = next_q[head_q[k]];
                len_d[k]          = len_q[k] - LenW'(1);
            end
        end
        if (pop && ArbMode == ARB_ROUND_ROBIN) begin
            rr_d = sel + IDWidth'(1);
        end
        if (push) begin
            link_we          = (len_d[in_id] != '0);
            free_d[free_idx] = 1'b0;
            if (len_d[in_id] == '0) begin
                head_d[in_id] = free_idx;
            end
            tail_d[in_id] = free_idx;
            len_d[in_id]  = len_d[in_id] + LenW'(1);
        end
    end

    // List bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
            rr_q   <= '0;
            for (int unsigned k = 0; k < NumIds; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                len_q[k]  <= '0;
            end
        end else begin
            free_q <= free_d;
            rr_q   <= rr_d;
            head_q <= head_d;
            tail_q <= tail_d;
            len_q  <= len_d;
        end
    end

    // Payload and link storage; contents are only meaningful while allocated.
    always_ff @(posedge clk_i) begin
        if (push) begin
            payload_q[free_idx] <= bus.data_i[StructWidth-1:IDWidth];
            if (link_we) begin
                next_q[tail_q[in_id]] <= free_idx;
            end
        end
    end

endmodule

// File: tb/tb_simmem_idlist_buffer.sv
// Scoreboard bench: two buffers (round-robin and fixed priority) share one
// stimulus stream and are checked against per-ID reference queues.
module tb_simmem_idlist_buffer;
    import simmem_pkg::*;

    localparam int unsigned SW  = 16;
    localparam int unsigned CAP = 8;
    localparam int unsigned IW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rel = '0;
    logic [15:0] din = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    simmem_idlist_buffer_if #(.StructWidth(SW), .IDWidth(IW)) bus_rr ();
    simmem_idlist_buffer_if #(.StructWidth(SW), .IDWidth(IW)) bus_fx ();

    assign bus_rr.release_en_i = rel;
    assign bus_rr.data_i       = din;
    assign bus_rr.in_valid_i   = in_valid;
    assign bus_rr.out_ready_i  = out_ready;
    assign bus_fx.release_en_i = rel;
    assign bus_fx.data_i       = din;
    assign bus_fx.in_valid_i   = in_valid;
    assign bus_fx.out_ready_i  = out_ready;

    simmem_idlist_buffer #(
        .StructWidth(SW), .TotalCapacity(CAP), .IDWidth(IW), .ArbMode(ARB_ROUND_ROBIN)
    ) dut_rr (.clk_i(clk), .rst_ni(rst_n), .bus(bus_rr));

    simmem_idlist_buffer #(
        .StructWidth(SW), .TotalCapacity(CAP), .IDWidth(IW), .ArbMode(ARB_FIXED)
    ) dut_fx (.clk_i(clk), .rst_ni(rst_n), .bus(bus_fx));

    logic        ov [2];
    logic [15:0] dout [2];
    logic [3:0]  ne [2];
    logic        fl [2];
    logic        ir [2];
    assign ov[0] = bus_rr.out_valid_o;  assign ov[1] = bus_fx.out_valid_o;
    assign dout[0] = bus_rr.data_o;     assign dout[1] = bus_fx.data_o;
    assign ne[0] = bus_rr.nonempty_o;   assign ne[1] = bus_fx.nonempty_o;
    assign fl[0] = bus_rr.full_o;       assign fl[1] = bus_fx.full_o;
    assign ir[0] = bus_rr.in_ready_o;   assign ir[1] = bus_fx.in_ready_o;

    // Reference model: one FIFO of whole messages per ID, per DUT.
    logic [15:0] mq [2][4][$];
    int          mrr = 0;
    int          glog [2][$];
    bit          logging = 1'b0;

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare outputs with the model, then apply this cycle's
    // accepted push/pop to the model.
    always @(negedge clk) begin : monitor
        int cnt, sel, id, s, z;
        bit any;
        logic [3:0] exp_ne;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) mq[d][k].delete();
                chk($sformatf("rst_valid%0d", d), ov[d], 0);
                chk($sformatf("rst_nonempty%0d", d), ne[d], 0);
                chk($sformatf("rst_full%0d", d), fl[d], 0);
                chk($sformatf("rst_ready%0d", d), ir[d], 1);
            end
            mrr = 0;
        end else begin
            s = 0;
            z = 0;
            for (int k = 0; k < 4; k++) s += int'(dut_rr.len_q[k]);
            for (int i = 0; i < CAP; i++) z += (dut_rr.free_q[i] == 1'b0) ? 1 : 0;
            chk("len_vs_free", s, z);
            for (int d = 0; d < 2; d++) begin
                cnt = 0;
                exp_ne = '0;
                for (int k = 0; k < 4; k++) begin
                    cnt += mq[d][k].size();
                    exp_ne[k] = (mq[d][k].size() != 0);
                end
                any = 1'b0;
                sel = 0;
                for (int i = 0; i < 4; i++) begin
                    id = (d == 0) ? (mrr + i) % 4 : i;
                    if (!any && mq[d][id].size() != 0 && rel[id]) begin
                        any = 1'b1;
                        sel = id;
                    end
                end
                chk($sformatf("out_valid%0d", d), ov[d], any);
                if (any) chk($sformatf("data_o%0d", d), dout[d], mq[d][sel][0]);
                chk($sformatf("nonempty%0d", d), ne[d], exp_ne);
                chk($sformatf("full%0d", d), fl[d], cnt == CAP);
                chk($sformatf("in_ready%0d", d), ir[d], cnt != CAP);
                if (any && out_ready) begin
                    void'(mq[d][sel].pop_front());
                    if (d == 0) mrr = (sel + 1) % 4;
                    if (logging) glog[d].push_back(sel);
                end
                if (in_valid && cnt != CAP) mq[d][din[1:0]].push_back(din);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        din = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rel = 4'hF;
        out_ready = 1'b1;
        cyc(CAP + 2);
        out_ready = 1'b0;
        rel = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc();
    endtask

    int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
    int exp_fx [6] = '{0, 0, 1, 1, 3, 3};

    initial begin
        do_reset();

        // Per-ID FIFO order on ID1.
        push(16'h1101); push(16'h2201); push(16'h3301);
        rel = 4'b0010; out_ready = 1'b1;
        cyc(4);
        out_ready = 1'b0; rel = '0;
        chk("fifo_nonempty_end", bus_rr.nonempty_o, 4'b0000);

        // Fill, then pop with a simultaneous (refused) push.
        for (int i = 0; i < CAP; i++) push(16'(($urandom & 16'hFFFC) | (i % 4)));
        chk("full_set", bus_rr.full_o, 1'b1);
        in_valid = 1'b1; din = 16'hDEAD; rel = 4'hF; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0; rel = '0;
        chk("full_clear", bus_rr.full_o, 1'b0);
        drain();

        // Same-ID push and pop with a single-entry list.
        push(16'hAA02);
        rel = 4'b0100; out_ready = 1'b1; in_valid = 1'b1; din = 16'hBB02;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("same_id_data", bus_rr.data_o, 16'hBB02);
        chk("same_id_len", dut_rr.len_q[2], 1);
        drain();

        // Arbitration order from a fresh round-robin pointer.
        do_reset();
        push(16'h1100); push(16'h1101); push(16'h1103);
        push(16'h2200); push(16'h2201); push(16'h2203);
        logging = 1'b1;
        rel = 4'hF; out_ready = 1'b1;
        cyc(6);
        out_ready = 1'b0; rel = '0; logging = 1'b0;
        chk("rr_count", glog[0].size(), 6);
        chk("fx_count", glog[1].size(), 6);
        for (int i = 0; i < 6 && i < glog[0].size(); i++) chk($sformatf("rr_order%0d", i), glog[0][i], exp_rr[i]);
        for (int i = 0; i < 6 && i < glog[1].size(); i++) chk($sformatf("fx_order%0d", i), glog[1][i], exp_fx[i]);

        // Release gating on ID0.
        push(16'h5500);
        cyc();
        rel = 4'b0001;
        #2;
        chk("gate_valid", bus_rr.out_valid_o, 1'b1);
        cyc();
        drain();

        // Reset mid-operation, then a clean push to ID3.
        for (int i = 0; i < 5; i++) push(16'(($urandom & 16'hFFFC) | (i % 4)));
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc();
        push(16'h7703);
        rel = 4'b1000;
        #2;
        chk("post_reset_data", bus_rr.data_o, 16'h7703);
        out_ready = 1'b1;
        cyc(2);
        out_ready = 1'b0; rel = '0;

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom % 3) != 0;
            din = 16'($urandom);
            rel = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
            out_ready = ($urandom % 4) != 0;
            cyc();
        end
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
